cordic_tx_packer: RTL and testbench

CORDIC_TX_PACKER -- requirements
Module: cordic_tx_packer

---
 rtl/cordic_uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/cordic_tx_packer.sv | 158 +++++++++++++++
 tb/tb_cordic_tx_packer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_uart_pkg.sv
// Shared constants and types for the CORDIC result UART packer.
// CORDIC_TX_CHECKSUM_EN selects the 6-byte frame that ends in an XOR checksum.
package cordic_uart_pkg;

    localparam logic [7:0] FRAME_HDR       = 8'hA5;
    localparam int         FRAME_LEN_CSUM  = 6;
    localparam int         FRAME_LEN_PLAIN = 5;

`ifdef CORDIC_TX_CHECKSUM_EN
    localparam int FRAME_LEN = FRAME_LEN_CSUM;
`else
    localparam int FRAME_LEN = FRAME_LEN_PLAIN;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR   = 3'd1,
        SIN_H = 3'd2,
        SIN_L = 3'd3,
        COS_H = 3'd4,
        COS_L = 3'd5,
        CSUM  = 3'd6
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read of the head entry and an occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];
    assign level   = count;

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cordic_tx_packer.sv
// Buffers CORDIC sin/cos results and streams them to a UART as A5-headed byte frames.
// Define CORDIC_TX_CHECKSUM_EN to append the XOR of the four payload bytes.
module cordic_tx_packer
    import cordic_uart_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_res_valid,
    input  logic [DATA_W-1:0]             i_sin,
    input  logic [DATA_W-1:0]             i_cos,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready,
    input  logic                          i_ovf_clr,
    output logic                          o_ovf,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int        WORD_W     = 2 * DATA_W;
    localparam tx_state_t LAST_STATE = (FRAME_LEN == FRAME_LEN_CSUM) ? CSUM : COS_L;

    tx_state_t         state;
    tx_state_t         next_state;
    logic [WORD_W-1:0] frame;
    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;
    logic              handshake;
    logic              frame_done;
    logic              tx_valid;
    logic              next_valid;
    logic [7:0]        tx_data;
    logic [7:0]        next_data;
    logic              ovf;
    logic [7:0]        sin_hi;
    logic [7:0]        sin_lo;
    logic [7:0]        cos_hi;
    logic [7:0]        cos_lo;
`ifdef CORDIC_TX_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (i_res_valid),
        .pop     (pop),
        .wdata   ({i_sin, i_cos}),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (o_level)
    );

    assign sin_hi = frame[WORD_W-1 -: 8];
    assign sin_lo = frame[WORD_W-9 -: 8];
    assign cos_hi = frame[DATA_W-1 -: 8];
    assign cos_lo = frame[DATA_W-9 -: 8];
`ifdef CORDIC_TX_CHECKSUM_EN
    assign csum   = sin_hi ^ sin_lo ^ cos_hi ^ cos_lo;
`endif

    assign handshake  = tx_valid && i_tx_ready;
    assign frame_done = handshake && (state == LAST_STATE);
    assign drop       = i_res_valid && fifo_full && !pop;

    assign o_tx_valid = tx_valid;
    assign o_tx_data  = tx_data;
    assign o_ovf      = ovf;
    assign o_busy     = (state != IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            frame    <= '0;
        end else begin
            state    <= next_state;
            tx_valid <= next_valid;
            tx_data  <= next_data;
            if (pop) begin
                frame <= fifo_rdata;
            end
        end
    end

    // IDLE and the last-byte handshake share one path, so back-to-back frames have no gap.
    always_comb begin
        next_state = state;
        next_valid = tx_valid;
        next_data  = tx_data;
        pop        = 1'b0;
        if (state == IDLE || frame_done) begin
            if (!fifo_empty) begin
                pop        = 1'b1;
                next_state = HDR;
                next_valid = 1'b1;
                next_data  = FRAME_HDR;
            end else begin
                next_state = IDLE;
                next_valid = 1'b0;
                next_data  = 8'h00;
            end
        end else if (handshake) begin
            case (state)
                HDR: begin
                    next_state = SIN_H;
                    next_data  = sin_hi;
                end
                SIN_H: begin
                    next_state = SIN_L;
                    next_data  = sin_lo;
                end
                SIN_L: begin
                    next_state = COS_H;
                    next_data  = cos_hi;
                end
                COS_H: begin
                    next_state = COS_L;
                    next_data  = cos_lo;
                end
`ifdef CORDIC_TX_CHECKSUM_EN
                COS_L: begin
                    next_state = CSUM;
                    next_data  = csum;
                end
`endif
                default: begin
                    next_state = IDLE;
                    next_valid = 1'b0;
                    next_data  = 8'h00;
                end
            endcase
        end
    end

    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cordic_tx_packer.sv
// Bench for cordic_tx_packer: a queue-based frame model checked every cycle plus directed literal checks.
// Honours CORDIC_TX_CHECKSUM_EN the same way the design does.
module tb_cordic_tx_packer;
    import cordic_uart_pkg::*;

    localparam int DEPTH = 8;
    localparam int FL    = FRAME_LEN;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        res_valid = 1'b0;
    logic        tx_ready  = 1'b0;
    logic        ovf_clr   = 1'b0;
    logic [15:0] sin_in    = 16'h0000;
    logic [15:0] cos_in    = 16'h0000;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        ovf;
    logic        busy;
    logic [3:0]  level;

    int checks = 0;
    int errors = 0;

    cordic_tx_packer #(
        .DATA_W     (16),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_res_valid (res_valid),
        .i_sin       (sin_in),
        .i_cos       (cos_in),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .i_ovf_clr   (ovf_clr),
        .o_ovf       (ovf),
        .o_busy      (busy),
        .o_level     (level)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Model: accepted results wait in m_fifo; the frame on the wire is a queue of its remaining bytes.
    logic [31:0] m_fifo[$];
    logic [7:0]  m_bytes[$];
    logic        m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin : model
        bit          hs;
        bit          take;
        bit          keep;
        logic [31:0] w;
        if (!rst_n) begin
            m_fifo.delete();
            m_bytes.delete();
            m_ovf = 1'b0;
        end else begin
            hs   = (m_bytes.size() != 0) && tx_ready;
            take = ((m_bytes.size() == 0) || (hs && m_bytes.size() == 1)) && (m_fifo.size() != 0);
            keep = res_valid && ((m_fifo.size() < DEPTH) || take);
            if (hs) void'(m_bytes.pop_front());
            if (take) begin
                w = m_fifo.pop_front();
                m_bytes.push_back(8'hA5);
                m_bytes.push_back(w[31:24]);
                m_bytes.push_back(w[23:16]);
                m_bytes.push_back(w[15:8]);
                m_bytes.push_back(w[7:0]);
`ifdef CORDIC_TX_CHECKSUM_EN
                m_bytes.push_back(w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]);
`endif
            end
            if (keep) m_fifo.push_back({sin_in, cos_in});
            if (res_valid && !keep) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        check_output("m_valid", 32'(tx_valid), 32'(m_bytes.size() != 0));
        if (m_bytes.size() != 0) check_output("m_data", 32'(tx_data), 32'(m_bytes[0]));
        check_output("m_busy", 32'(busy), 32'(m_bytes.size() != 0));
        check_output("m_level", 32'(level), 32'(m_fifo.size()));
        check_output("m_ovf", 32'(ovf), 32'(m_ovf));
    end

    // Byte capture of every handshake, tagged with its cycle number.
    logic [7:0] cap[$];
    int         cap_cyc[$];
    int         cyc   = 0;
    int         peak  = 0;
    bit         track = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && tx_valid && tx_ready) begin
            cap.push_back(tx_data);
            cap_cyc.push_back(cyc);
        end
        if (track && int'(level) > peak) peak = int'(level);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [15:0] s, input logic [15:0] c);
        sin_in    = s;
        cos_in    = c;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic wait_bytes(input string name, input int n, input int bound);
        int k = 0;
        @(negedge clk);
        #1;
        while (cap.size() < n && k < bound) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_output(name, 32'(cap.size()), 32'(n));
    endtask

    task automatic wait_idle(input string name, input int bound);
        int k = 0;
        @(negedge clk);
        while (busy && k < bound) begin
            @(negedge clk);
            k++;
        end
        check_output(name, 32'(busy), 32'd0);
        tick();
    endtask

    task automatic check_frame(input string name, input logic [47:0] exp);
        logic [7:0] b;
        for (int i = 0; i < FL; i++) begin
            b = (i < cap.size()) ? cap[i] : 8'hxx;
            check_output($sformatf("%s_b%0d", name, i), 32'(b), 32'(exp[47 - 8*i -: 8]));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check_output({name, "_valid"}, 32'(tx_valid), 32'd0);
        check_output({name, "_data"}, 32'(tx_data), 32'd0);
        check_output({name, "_ovf"}, 32'(ovf), 32'd0);
        check_output({name, "_busy"}, 32'(busy), 32'd0);
        check_output({name, "_level"}, 32'(level), 32'd0);
    endtask

    initial begin
        $display("[TB] start, frame length %0d", FL);
        repeat (3) tick();
        @(negedge clk);
        check_reset_outputs("rst");
        tick();
        rst_n = 1'b1;

        // Single frame with the receiver always ready.
        tx_ready = 1'b1;
        cap.delete();
        cap_cyc.delete();
        apply_stimulus(16'h1234, 16'hABCD);
        wait_bytes("t1_count", FL, 30);
        check_frame("t1", 48'hA5_1234_ABCD_40);
        check_output("t1_contig", 32'(cap_cyc[FL-1] - cap_cyc[0]), 32'(FL - 1));
        @(negedge clk);
        check_output("t1_busy_end", 32'(busy), 32'd0);
        check_output("t1_valid_end", 32'(tx_valid), 32'd0);
        tick();

        // Random receiver stalls must not change byte order or values.
        cap.delete();
        cap_cyc.delete();
        tx_ready = 1'b0;
        apply_stimulus(16'h7F01, 16'h8002);
        for (int i = 0; i < 200 && cap.size() < FL; i++) begin
            tx_ready = (i < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end
        tx_ready = 1'b1;
        check_output("t2_count", 32'(cap.size()), 32'(FL));
        check_frame("t2", 48'hA5_7F01_8002_FC);
        wait_idle("t2_idle", 20);

        // Three results back to back stream without gaps between frames.
        cap.delete();
        cap_cyc.delete();
        peak  = 0;
        track = 1'b1;
        apply_stimulus(16'h1111, 16'h2222);
        apply_stimulus(16'h3333, 16'h4444);
        apply_stimulus(16'h5555, 16'h6666);
        wait_bytes("t3_count", 3 * FL, 100);
        track = 1'b0;
        check_output("t3_peak", 32'(peak), 32'd2);
        check_output("t3_contig", 32'(cap_cyc[3*FL-1] - cap_cyc[0]), 32'(3 * FL - 1));
        wait_idle("t3_idle", 20);

        // Receiver blocked: ten results fill the FIFO behind a pending header and one is dropped.
        tx_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(16'h1000 + 16'(i), 16'h2000 + 16'(i));
        end
        tick();
        @(negedge clk);
        check_output("t4_level", 32'(level), 32'd8);
        check_output("t4_ovf", 32'(ovf), 32'd1);
        check_output("t4_valid", 32'(tx_valid), 32'd1);
        check_output("t4_hdr", 32'(tx_data), 32'hA5);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        check_output("t4_ovf_clr", 32'(ovf), 32'd0);
        tick();
        ovf_clr = 1'b1;
        apply_stimulus(16'hDEAD, 16'hBEEF);
        ovf_clr = 1'b0;
        @(negedge clk);
        check_output("t4_set_wins", 32'(ovf), 32'd1);
        check_output("t4_level_hold", 32'(level), 32'd8);
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        @(negedge clk);
        check_output("t4_ovf_clr2", 32'(ovf), 32'd0);
        tick();

        // Full FIFO: a result landing on the last-byte handshake is accepted.
        tx_ready = 1'b1;
        repeat (FL - 1) tick();
        apply_stimulus(16'h4444, 16'h5555);
        @(negedge clk);
        check_output("t5_level", 32'(level), 32'd8);
        check_output("t5_ovf", 32'(ovf), 32'd0);
        wait_idle("t5_idle", 200);

        // Reset in the middle of a frame discards it; a later result sends a clean frame.
        cap.delete();
        cap_cyc.delete();
        apply_stimulus(16'hBEC3, 16'h0F96);
        begin : find_sin_l
            bit found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                @(negedge clk);
                if (tx_valid && tx_data == 8'hC3) found = 1'b1;
            end
            check_output("t6_reach_sin_l", 32'(found), 32'd1);
        end
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("t6_rst");
        tick();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("t6_no_resume", 32'(tx_valid), 32'd0);
        tick();
        cap.delete();
        cap_cyc.delete();
        apply_stimulus(16'hBEC3, 16'h0F96);
        wait_bytes("t6_count", FL, 30);
        check_frame("t6", 48'hA5_BEC3_0F96_E4);
        wait_idle("t6_idle", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
